// File: rtl/logic_op_arbiter.sv
// Purpose: two requesters share one bitwise AND/OR/XOR/XNOR unit under round-robin arbitration.
// Latency: the result is valid two cycles after the accept cycle; best-case round trip is 3 cycles.
// Backpressure: the result is held in DONE until res_ready; both request readies stay low outside IDLE.
module logic_op_arbiter #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,

  input  logic          req0_valid,
  input  logic [1:0]    req0_sel,
  input  logic [DW-1:0] req0_a,
  input  logic [DW-1:0] req0_b,
  output logic          req0_ready,

  input  logic          req1_valid,
  input  logic [1:0]    req1_sel,
  input  logic [DW-1:0] req1_a,
  input  logic [DW-1:0] req1_b,
  output logic          req1_ready,

  output logic          res_valid,
  output logic [DW-1:0] res_data,
  output logic          res_id,
  input  logic          res_ready,

  output logic          busy,
  output logic [15:0]   op_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic          rr_ptr;     // preferred requester when both are valid
  logic [1:0]    op_sel;     // latched operation
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic          op_id;      // owner of the latched operation

  logic          grant;      // requester that would be accepted in IDLE
  logic          accept;
  logic          in_idle;
  logic [1:0]    acc_sel;
  logic [DW-1:0] acc_a;
  logic [DW-1:0] acc_b;
  logic [DW-1:0] op_result;

  assign in_idle = (state == IDLE);

  // Pick a requester: a lone valid requester always wins, a tie goes to rr_ptr.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = rr_ptr;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  // Ready is only offered in IDLE, and only to the granted requester.
  assign req0_ready = in_idle && req0_valid && !grant;
  assign req1_ready = in_idle && req1_valid &&  grant;
  assign accept     = req0_ready || req1_ready;

  // Mux the granted requester's operands so the FSM latches a single source.
  always_comb begin
    acc_sel = req0_sel;
    acc_a   = req0_a;
    acc_b   = req0_b;
    if (grant) begin
      acc_sel = req1_sel;
      acc_a   = req1_a;
      acc_b   = req1_b;
    end
  end

  // Shared logic unit evaluated on the latched operands.
  always_comb begin
    case (op_sel)
      2'b00:   op_result = op_a & op_b;
      2'b01:   op_result = op_a | op_b;
      2'b10:   op_result = op_a ^ op_b;
      2'b11:   op_result = ~(op_a ^ op_b);
      default: op_result = op_a & op_b;
    endcase
  end

  // Controller: accept in IDLE, compute in EXEC, hold the result in DONE until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= 1'b0;
      op_sel    <= 2'b00;
      op_a      <= '0;
      op_b      <= '0;
      op_id     <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= 1'b0;
      busy      <= 1'b0;
      op_cnt    <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_sel <= acc_sel;
            op_a   <= acc_a;
            op_b   <= acc_b;
            op_id  <= grant;
            busy   <= 1'b1;
            state  <= EXEC;
          end
        end
        EXEC: begin
          res_data  <= op_result;
          res_id    <= op_id;
          res_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            rr_ptr    <= ~res_id;
            op_cnt    <= op_cnt + 16'd1;
            state     <= IDLE;
          end
        end
        default: begin
          res_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/logic_op_arbiter.md
# logic_op_arbiter

Shares one bitwise logic-operation unit (AND / OR / XOR / XNOR, selected by a 2-bit code) between two requesters. Round-robin arbitration with valid/ready handshakes on both request ports and the result port. A three-state controller sequences each operation: accept, execute into a result register, then hold until the consumer accepts. Sits between two command sources and a single result consumer in the logic-unit datapath.

## Interface
- `DW`, default 8: operand and result width in bits.
- `clk` input 1: system clock, rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `req0_valid` input 1: requester 0 has an operation pending.
- `req0_sel` input 2: requester 0 op code: 00 AND, 01 OR, 10 XOR, 11 XNOR.
- `req0_a`, `req0_b` input DW: requester 0 operands.
- `req0_ready` output 1: requester 0 operation accepted this cycle when `req0_valid` is also high.
- `req1_valid`, `req1_sel`, `req1_a`, `req1_b`, `req1_ready`: same as requester 0.
- `res_valid` output 1: result available.
- `res_data` output DW: result, bitwise op of latched operands.
- `res_id` output 1: index of the requester that owns the result.
- `res_ready` input 1: consumer accepts the result when `res_valid` is also high.
- `busy` output 1: controller is not in IDLE.
- `op_cnt` output 16: count of completed results (result handshakes).

## Operation
- States: IDLE, EXEC, DONE.
- IDLE:
  - Grant = requester with valid high. If both are valid, grant goes to `rr_ptr` (0 after reset).
  - `reqN_ready` = 1 only for the granted requester, combinational, and only in IDLE.
  - On accept, latch sel/a/b and id, then go to EXEC.
  - With no valid request, stay in IDLE.
- EXEC (exactly 1 cycle):
  - `res_data` <= op(a, b) per latched sel. Bitwise, width DW.
  - `res_id` <= latched id. Go to DONE.
- DONE:
  - `res_valid` = 1. `res_data` and `res_id` are held stable.
  - When `res_ready` = 1: go to IDLE, set `rr_ptr` <= ~`res_id`, and increment `op_cnt` (wraps 0xFFFF -> 0x0000).
- Outside IDLE both ready outputs are 0. Requests are held by the requesters, never dropped or queued.
- A single requester alone is always granted regardless of `rr_ptr`.
- Undefined sel cannot occur (all 4 codes decoded). The default branch gives AND.
- `busy` = (state != IDLE).

## Timing
- Reset (async assert, sync-safe release): state IDLE, `rr_ptr` 0, `res_valid` 0, `res_data` 0, `res_id` 0, `op_cnt` 0, `busy` 0. Ready outputs follow IDLE decode.
- Reset mid-operation aborts the operation. The latched operation is discarded and no result is produced.
- Latency: accept at edge T, `res_valid` high after edge T+2.
- Fastest round trip is 3 cycles per operation, with `res_ready` tied high:
  - IDLE accept, EXEC, DONE handshake.
  - The next accept comes in the cycle after DONE.
- `res_ready` high while not in DONE has no effect.
- A requester dropping valid before its grant is legal. Nothing is latched.
- Ready depends combinationally on valid and state. No combinational path from `res_ready` to the request ports.

## Test plan
- Reset values: assert `rst_n` = 0, release, idle 5 cycles -> all outputs 0, both readies 0, `busy` 0.
- Single op:
  - Stimulus: req0 sel 10, a 0xF0, b 0x3C, `res_ready` = 1.
  - Response: `req0_ready` 1 at the accept cycle; `res_valid` 2 cycles later; `res_data` 0xCC; `res_id` 0; `op_cnt` 1.
- All op codes: req1 with a 0xA5, b 0x0F, sel 00/01/10/11 -> results 0x05 / 0xAF / 0xAA / 0x55, each tagged `res_id` 1.
- Round-robin: both valid continuously, 4 ops -> grant order 0, 1, 0, 1. Each result's id matches its requester's operands.
- Backpressure:
  - Stimulus: `res_ready` = 0 for 10 cycles in DONE.
  - Response: `res_valid`, `res_data` and `res_id` are stable; both readies stay 0; `op_cnt` does not change until `res_ready` is raised.
- Reset mid-op:
  - Stimulus: drop `rst_n` during EXEC.
  - Response: outputs return to reset values immediately, and no result handshake occurs for the aborted op.
  - After release, a new req0 op completes normally.
